get_reg: RTL and testbench



---
 rtl/get_reg.sv | 98 +++++++++
 tb/tb_get_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/get_reg.sv
// get_reg: RISC-V GPR number <-> ABI mnemonic translator.
// Strings are right-justified ASCII: the last character sits in [7:0] and
// unused upper bytes are zero. One registered lookup per cycle, latency 1.
module get_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_mode,
    input  logic [5:0]  req_idx,
    input  logic [32:0] req_name,
    output logic        rsp_valid,
    output logic [32:0] rsp_name,
    output logic [4:0]  rsp_idx,
    output logic        rsp_hit
);

    // "fp" is accepted on the reverse path as an alias of s0
    localparam logic [32:0] FP_NAME = 33'h0_0000_6670;

    // Canonical ABI name for GPR i. Runs of names share a prefix, so each run
    // is its first entry plus an offset into the trailing digit.
    function automatic logic [32:0] name_of(input logic [4:0] i);
        logic [32:0] n;
        if (i == 5'd0)
            n = 33'h0_7A65_726F;                        // zero
        else if (i == 5'd1)
            n = 33'h0_0000_7261;                        // ra
        else if (i == 5'd2)
            n = 33'h0_0000_7370;                        // sp
        else if (i == 5'd3)
            n = 33'h0_0000_6770;                        // gp
        else if (i == 5'd4)
            n = 33'h0_0000_7470;                        // tp
        else if (i <= 5'd7)
            n = 33'h0_0000_7430 + 33'(i - 5'd5);        // t0..t2
        else if (i <= 5'd9)
            n = 33'h0_0000_7330 + 33'(i - 5'd8);        // s0..s1
        else if (i <= 5'd17)
            n = 33'h0_0000_6130 + 33'(i - 5'd10);       // a0..a7
        else if (i <= 5'd25)
            n = 33'h0_0000_7332 + 33'(i - 5'd18);       // s2..s9
        else if (i <= 5'd27)
            n = 33'h0_0073_3130 + 33'(i - 5'd26);       // s10..s11
        else
            n = 33'h0_0000_7433 + 33'(i - 5'd28);       // t3..t6
        return n;
    endfunction

    logic [32:0] nxt_name;
    logic [4:0]  nxt_idx;
    logic        nxt_hit;

    // Lookup: forward indexes the table, reverse compares against every entry.
    // A miss in either direction reports all-zero results.
    always_comb begin
        nxt_name = '0;
        nxt_idx  = '0;
        nxt_hit  = 1'b0;
        if (!req_mode) begin
            if (!req_idx[5]) begin
                nxt_name = name_of(req_idx[4:0]);
                nxt_idx  = req_idx[4:0];
                nxt_hit  = 1'b1;
            end
        end else begin
            for (int k = 0; k < 32; k++) begin
                if (req_name == name_of(5'(k))) begin
                    nxt_name = req_name;
                    nxt_idx  = 5'(k);
                    nxt_hit  = 1'b1;
                end
            end
            if (req_name == FP_NAME) begin
                nxt_name = name_of(5'd8);
                nxt_idx  = 5'd8;
                nxt_hit  = 1'b1;
            end
        end
    end

    // Output registers: strobe follows req_valid, data holds while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_name  <= '0;
            rsp_idx   <= '0;
            rsp_hit   <= 1'b0;
        end else begin
            rsp_valid <= req_valid;
            if (req_valid) begin
                rsp_name <= nxt_name;
                rsp_idx  <= nxt_idx;
                rsp_hit  <= nxt_hit;
            end
        end
    end

endmodule

// File: tb/tb_get_reg.sv
// Directed self-checking bench for get_reg.
module tb_get_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_mode;
    logic [5:0]  req_idx;
    logic [32:0] req_name;
    logic        rsp_valid;
    logic [32:0] rsp_name;
    logic [4:0]  rsp_idx;
    logic        rsp_hit;

    int n_tests = 0;
    int n_fail  = 0;

    get_reg dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_idx   (req_idx),
        .req_name  (req_name),
        .rsp_valid (rsp_valid),
        .rsp_name  (rsp_name),
        .rsp_idx   (rsp_idx),
        .rsp_hit   (rsp_hit)
    );

    always #5 clk = ~clk;

    // Hand-written ABI name table
    logic [31:0] names [32] = '{
        32'h7A65726F, 32'h00007261, 32'h00007370, 32'h00006770,
        32'h00007470, 32'h00007430, 32'h00007431, 32'h00007432,
        32'h00007330, 32'h00007331, 32'h00006130, 32'h00006131,
        32'h00006132, 32'h00006133, 32'h00006134, 32'h00006135,
        32'h00006136, 32'h00006137, 32'h00007332, 32'h00007333,
        32'h00007334, 32'h00007335, 32'h00007336, 32'h00007337,
        32'h00007338, 32'h00007339, 32'h00733130, 32'h00733131,
        32'h00007433, 32'h00007434, 32'h00007435, 32'h00007436
    };

    typedef struct {
        string       tag;
        logic        mode;
        logic [5:0]  idx;
        logic [32:0] name;
        logic [32:0] e_name;
        logic [4:0]  e_idx;
        logic        e_hit;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [32:0] nm,
                           input logic [4:0] ix, input logic h);
        chk({tag, ".valid"}, 33'(rsp_valid), 33'(v));
        chk({tag, ".name"},  rsp_name, nm);
        chk({tag, ".idx"},   33'(rsp_idx), 33'(ix));
        chk({tag, ".hit"},   33'(rsp_hit), 33'(h));
    endtask

    task automatic drive(input logic v, input logic m, input logic [5:0] ix, input logic [32:0] nm);
        req_valid = v;
        req_mode  = m;
        req_idx   = ix;
        req_name  = nm;
    endtask

    initial begin
        logic [32:0] fwd_name;

        vecs[0] = '{"oor32", 1'b0, 6'd32, 33'h0, 33'h0, 5'd0, 1'b0};
        vecs[1] = '{"oor63", 1'b0, 6'd63, 33'h0, 33'h0, 5'd0, 1'b0};
        vecs[2] = '{"rev_a7", 1'b1, 6'd0, 33'h0_0000_6137, 33'h0_0000_6137, 5'd17, 1'b1};
        vecs[3] = '{"rev_fp", 1'b1, 6'd0, 33'h0_0000_6670, 33'h0_0000_7330, 5'd8, 1'b1};
        vecs[4] = '{"rev_RA", 1'b1, 6'd0, 33'h0_0000_5241, 33'h0, 5'd0, 1'b0};
        vecs[5] = '{"rev_bit32", 1'b1, 6'd0, 33'h1_0000_7261, 33'h0, 5'd0, 1'b0};
        vecs[6] = '{"rev_zero", 1'b1, 6'd0, 33'h0_7A65_726F, 33'h0_7A65_726F, 5'd0, 1'b1};
        vecs[7] = '{"rev_s11", 1'b1, 6'd0, 33'h0_0073_3131, 33'h0_0073_3131, 5'd27, 1'b1};
        vecs[8] = '{"rev_pad", 1'b1, 6'd0, 33'h0_0100_7261, 33'h0, 5'd0, 1'b0};
        vecs[9] = '{"fwd_t6", 1'b0, 6'd31, 33'h0, 33'h0_0000_7436, 5'd31, 1'b1};

        reset = 1'b0;
        drive(1'b1, 1'b0, 6'd1, 33'h0);
        repeat (2) @(posedge clk);
        #1 chk_rsp("reset", 1'b0, 33'h0, 5'd0, 1'b0);

        // release between edges, idle one cycle
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 33'h0);
        @(posedge clk);
        #1 chk("idle.valid", 33'(rsp_valid), 33'h0);

        // forward sweep back-to-back
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 6'(i), 33'h0);
            @(posedge clk);
            #1 chk_rsp($sformatf("fwd%0d", i), 1'b1, {1'b0, names[i]}, 5'(i), 1'b1);
        end

        // table vectors
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].idx, vecs[i].name);
            @(posedge clk);
            #1 chk_rsp(vecs[i].tag, 1'b1, vecs[i].e_name, vecs[i].e_idx, vecs[i].e_hit);
        end

        // round trip through forward then reverse
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 6'(i), 33'h0);
            @(posedge clk);
            #1 fwd_name = rsp_name;
            drive(1'b1, 1'b1, 6'd0, fwd_name);
            @(posedge clk);
            #1 chk_rsp($sformatf("rt%0d", i), 1'b1, {1'b0, names[i]}, 5'(i), 1'b1);
        end

        // single request then idle: one pulse, data held
        drive(1'b1, 1'b0, 6'd5, 33'h0);
        @(posedge clk);
        #1 chk_rsp("hold0", 1'b1, 33'h0_0000_7430, 5'd5, 1'b1);
        drive(1'b0, 1'b0, 6'd9, 33'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 chk_rsp($sformatf("hold%0d", c + 1), 1'b0, 33'h0_0000_7430, 5'd5, 1'b1);
        end

        // async reset while streaming
        drive(1'b1, 1'b0, 6'd26, 33'h0);
        @(posedge clk);
        #1 chk_rsp("pre_rst", 1'b1, 33'h0_0073_3130, 5'd26, 1'b1);
        #2 reset = 1'b0;
        #1 chk_rsp("rst_async", 1'b0, 33'h0, 5'd0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1 chk_rsp($sformatf("rst_hold%0d", c), 1'b0, 33'h0, 5'd0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 6'd1, 33'h0);
        @(posedge clk);
        #1 chk_rsp("post_rst", 1'b1, 33'h0_0000_7261, 5'd1, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 33'h0);
        @(posedge clk);
        #1 chk("post_rst.drop", 33'(rsp_valid), 33'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
